// File: rtl/qkd_pkg.sv
// qkd_pkg: shared constants, default seeds and FSM state type for the BB84 emulation core
package qkd_pkg;
    localparam int KEY_W_DEF = 128;
    localparam int LFSR_W = 16;
    localparam int TAP0 = 15;
    localparam int TAP1 = 13;
    localparam int TAP2 = 12;
    localparam int TAP3 = 10;
    localparam logic [LFSR_W-1:0] SEED_A_DEF = 16'hACE1;
    localparam logic [LFSR_W-1:0] SEED_AB_DEF = 16'h1D2B;
    localparam logic [LFSR_W-1:0] SEED_BB_DEF = 16'h5A5A;
    localparam logic [LFSR_W-1:0] SEED_E_DEF = 16'h3C96;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/qkd_lfsr16.sv
// qkd_lfsr16: 16-bit Fibonacci LFSR, loads SEED on reset and steps while en is high
// Ports: clk, rst (sync, active-low), en (advance), state (current register), out_bit (state[0])
module qkd_lfsr16
    import qkd_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_A_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state,
    output logic              out_bit
);
    always_ff @(posedge clk)
        if (!rst) state <= SEED;
        else if (en) state <= {state[LFSR_W-2:0], state[TAP0] ^ state[TAP1] ^ state[TAP2] ^ state[TAP3]};
    assign out_bit = state[0];
endmodule

// File: rtl/qkd_core.sv
// qkd_core: BB84 emulation; LFSR-driven bits/bases, basis sifting, first KEY_W sifted bits form final_key
// Ports: clk, rst (sync, active-low), final_key (Bob's sifted key), key_valid, err_count (saturating at 255)
// Build option: QKD_EVE_EN adds an intercept-resend eavesdropper with its own basis LFSR
module qkd_core
    import qkd_pkg::*;
#(
    parameter int                KEY_W   = KEY_W_DEF,
    parameter logic [LFSR_W-1:0] SEED_A  = SEED_A_DEF,
    parameter logic [LFSR_W-1:0] SEED_AB = SEED_AB_DEF,
    parameter logic [LFSR_W-1:0] SEED_BB = SEED_BB_DEF,
    parameter logic [LFSR_W-1:0] SEED_E  = SEED_E_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [KEY_W-1:0] final_key,
    output logic             key_valid,
    output logic [7:0]       err_count
);
    state_t state_q, state_d;
    logic [LFSR_W-1:0] a_st, ab_st, bb_st;
    logic a_bit, a_basis, b_basis, b_bit, en, match, last, unused_st;
    logic [7:0] cnt;
    logic [KEY_W-1:0] sift_reg, sift_nxt;

    assign en = state_q == RUN;
    qkd_lfsr16 #(.SEED(SEED_A))  u_a  (.clk(clk), .rst(rst), .en(en), .state(a_st),  .out_bit(a_bit));
    qkd_lfsr16 #(.SEED(SEED_AB)) u_ab (.clk(clk), .rst(rst), .en(en), .state(ab_st), .out_bit(a_basis));
    qkd_lfsr16 #(.SEED(SEED_BB)) u_bb (.clk(clk), .rst(rst), .en(en), .state(bb_st), .out_bit(b_basis));
`ifdef QKD_EVE_EN
    logic [LFSR_W-1:0] e_st;
    logic e_basis;
    qkd_lfsr16 #(.SEED(SEED_E))  u_e  (.clk(clk), .rst(rst), .en(en), .state(e_st),  .out_bit(e_basis));
    // Eve measuring in the wrong basis resends a random bit
    assign b_bit = (e_basis != a_basis) ? a_bit ^ e_st[1] : a_bit;
    assign unused_st = ^{a_st, ab_st, bb_st, e_st};
`else
    assign b_bit = a_bit;
    assign unused_st = ^{a_st, ab_st, bb_st, SEED_E};
`endif

    assign match = a_basis == b_basis;
    assign last = cnt == 8'(KEY_W - 1);
    assign sift_nxt = b_bit ? sift_reg | ({{(KEY_W-1){1'b0}}, 1'b1} << cnt) : sift_reg;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = (match && last) ? DONE : RUN;
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst) begin
            state_q   <= IDLE;
            cnt       <= '0;
            sift_reg  <= '0;
            final_key <= '0;
            key_valid <= 1'b0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            if (en && match) begin
                sift_reg <= sift_nxt;
                cnt      <= cnt + 8'd1;
                if (b_bit != a_bit && err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (last) begin
                    final_key <= sift_nxt;
                    key_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_qkd_core.sv
// tb_qkd_core: directed checks of qkd_core against a behavioural BB84 sifting model
module tb_qkd_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [127:0] final_key;
    logic key_valid;
    logic [7:0] err_count;
    int errors = 0;
    int checks = 0;

    qkd_core dut (.clk(clk), .rst(rst), .final_key(final_key), .key_valid(key_valid), .err_count(err_count));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Photon-by-photon reference: returns Bob's key, Alice's key, RUN cycles used and error count
    task automatic run_model(output logic [127:0] key, output logic [127:0] akey, output int n, output int errs);
        logic [15:0] a = 16'hACE1;
        logic [15:0] ab = 16'h1D2B;
        logic [15:0] bb = 16'h5A5A;
        logic [15:0] e = 16'h3C96;
        logic bob;
        int c = 0;
        key = '0;
        akey = '0;
        n = 0;
        errs = 0;
        while (c < 128 && n < 5000) begin
            n++;
            if (ab[0] == bb[0]) begin
                bob = a[0];
`ifdef QKD_EVE_EN
                if (e[0] != ab[0]) bob = a[0] ^ e[1];
`endif
                key[c] = bob;
                akey[c] = a[0];
                if (bob != a[0] && errs < 255) errs++;
                c++;
            end
            a = nx(a);
            ab = nx(ab);
            bb = nx(bb);
            e = nx(e);
        end
    endtask

    initial begin
        logic [127:0] m_key, m_akey, k1;
        int m_n, m_err, cyc, cyc2;
        logic partial;
        run_model(m_key, m_akey, m_n, m_err);

        step();
        step();
        chk("reset_final_key", final_key, '0);
        chk("reset_key_valid", 128'(key_valid), 128'd0);
        chk("reset_err_count", 128'(err_count), 128'd0);

        rst = 1'b1;
        cyc = 0;
        partial = 1'b0;
        while (!key_valid && cyc < 1100) begin
            step();
            cyc++;
            if (!key_valid && final_key !== '0) partial = 1'b1;
        end
        chk("run_no_partial_key", 128'(partial), 128'd0);
        chk("key_valid_rises", 128'(key_valid), 128'd1);
        chk("completion_cycles", 128'(cyc), 128'(m_n + 1));
        chk("within_1024_run", 128'(cyc <= 1025), 128'd1);
        chk("final_key_model", final_key, m_key);
        chk("err_count_model", 128'(err_count), 128'(m_err));
`ifdef QKD_EVE_EN
        chk("eve_err_popcount", 128'($countones(final_key ^ m_akey)), 128'(err_count));
`else
        chk("noeve_err_zero", 128'(err_count), 128'd0);
        chk("noeve_popcount", 128'($countones(final_key)), 128'($countones(m_key)));
`endif
        k1 = final_key;

        repeat (500) step();
        chk("hold_final_key", final_key, m_key);
        chk("hold_key_valid", 128'(key_valid), 128'd1);
        chk("hold_err_count", 128'(err_count), 128'(m_err));

        rst = 1'b0;
        step();
        chk("done_reset_key", final_key, '0);
        chk("done_reset_valid", 128'(key_valid), 128'd0);
        chk("done_reset_err", 128'(err_count), 128'd0);

        rst = 1'b1;
        repeat (101) step();
        chk("midrun_not_done", 128'(key_valid), 128'd0);
        chk("midrun_key_zero", final_key, '0);
        rst = 1'b0;
        step();
        chk("midrun_reset_valid", 128'(key_valid), 128'd0);
        chk("midrun_reset_err", 128'(err_count), 128'd0);

        rst = 1'b1;
        cyc2 = 0;
        while (!key_valid && cyc2 < 1100) begin
            step();
            cyc2++;
        end
        chk("replay_valid", 128'(key_valid), 128'd1);
        chk("replay_key", final_key, k1);
        chk("replay_cycles", 128'(cyc2), 128'(cyc));
        chk("replay_err", 128'(err_count), 128'(m_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qkd_core.md
# qkd_core

Self-contained BB84 quantum-key-distribution emulation core. Pseudo-random generators model Alice's raw bits and bases and Bob's measurement bases. Sifting keeps bits where the bases match, and the first 128 sifted bits are assembled into a 128-bit key. The core sits at the top of the QKD datapath; downstream blocks consume `final_key` once `key_valid` rises.

## Interface
Parameters:
- `KEY_W`, default 128: key length in sifted bits.
- `SEED_A`, default 16'hACE1: seed for Alice's bit generator.
- `SEED_AB`, default 16'h1D2B: seed for Alice's basis generator.
- `SEED_BB`, default 16'h5A5A: seed for Bob's basis generator.
- `SEED_E`, default 16'h3C96: seed for Eve's basis generator; used only with `QKD_EVE_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `final_key`, out, `KEY_W`: completed sifted key (Bob's copy).
- `key_valid`, out, 1: high once `final_key` is complete.
- `err_count`, out, 8: number of sifted positions where Bob's bit differs from Alice's.

## Operation
- LFSRs:
  - Each generator is a 16-bit Fibonacci LFSR.
  - Next value is `{l[14:0], l[15]^l[13]^l[12]^l[10]}`.
  - The output bit is `l[0]`.
  - Seeds are never zero.
- FSM states:
  - IDLE: entered on reset. Moves to RUN on the first cycle with `rst`=1.
  - RUN: once per cycle, advance all LFSRs and evaluate one photon.
  - DONE: terminal until reset. LFSRs and counters freeze.
- Per RUN cycle, using the current LFSR outputs:
  - `a_bit`, `a_basis`, `b_basis`.
  - `match` = (`a_basis` == `b_basis`).
- Bob's bit:
  - On a match, `b_bit` = `a_bit` (lossless channel).
  - On a mismatch, the photon is discarded.
- Sifting:
  - On a match, write `b_bit` into `sift_reg[cnt]` (LSB first) and increment `cnt` (8-bit).
  - If `b_bit` != `a_bit`, increment `err_count`, saturating at 255.
- Completion: when `match` occurs and `cnt` == `KEY_W`-1:
  - load `final_key` with the completed `sift_reg`, including the current bit;
  - set `key_valid`=1;
  - enter DONE.
- `final_key` stays 0 until completion and then holds constant.
- Output is fully deterministic for given seeds.

## Timing
- Reset values: `final_key`=0, `key_valid`=0, `err_count`=0, `cnt`=0, `sift_reg`=0, LFSRs loaded with their seeds, state IDLE.
- Reset asserted in any state, including mid-RUN or DONE, restores all reset values on that edge.
- After reset release, the identical sequence replays.
- First photon is evaluated on the second rising edge after reset release: IDLE takes one cycle.
- `final_key` and `key_valid` update on the same edge as the 128th match. No partial key is ever visible.
- Required completion: at most 1024 RUN cycles with default seeds. The expected value is about 256.
- `err_count` is registered and reflects errors up to and including the previous edge.

## Configuration
- `QKD_EVE_EN` defined: an intercept-resend eavesdropper is compiled in.
  - A fourth LFSR (`SEED_E`) supplies `e_basis`.
  - On a match where `e_basis` != `a_basis`, `b_bit` = `a_bit` XOR `lE[1]` (randomised result).
  - Otherwise `b_bit` = `a_bit`.
  - This yields an error rate of about 25% on sifted bits, counted in `err_count`.
- `QKD_EVE_EN` undefined: no fourth LFSR and `b_bit` = `a_bit` on a match. `err_count` remains 0 permanently.

## Structure
- Package `qkd_pkg` holds:
  - `KEY_W` default;
  - LFSR width 16 and the tap constants;
  - the four default seeds;
  - the state enum (IDLE, RUN, DONE).
- Sub-module `qkd_lfsr16`:
  - ports `clk`, `rst`, `en`, seed parameter, 16-bit state, output bit;
  - instantiated three times, or four with `QKD_EVE_EN`.
- The top holds the FSM, sifting, counters and output registers.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles, then check `final_key`=0, `key_valid`=0 and `err_count`=0. Outputs must stay 0 in IDLE and throughout RUN until completion.
- Completion: release reset and run 100 µs at a 10 ns clock.
  - `key_valid`=1 within 1024 cycles.
  - `final_key` equals a behavioural model's LSB-first sifted key from the default seeds.
- Hold: after `key_valid`, run 500 more cycles. `final_key`, `key_valid` and `err_count` are unchanged.
- Reset mid-operation: assert reset at cycle 100 of RUN, then release. The completed key must be bit-identical to the uninterrupted run's key, and the completion cycle count from release must also match.
- No Eve (macro undefined): `err_count`=0 at completion and `popcount(final_key)` equals the model's value.
- Eve (`QKD_EVE_EN`): `err_count` equals the model's count, which should fall in 16..48 for 128 bits. `final_key` XOR the model's Alice key has popcount equal to `err_count`.
